inst_cache: RTL and testbench
=============================

INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 SHALL have parameter LINE_BYTES, fixed 16, bytes per line (4 x 32-bit words).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port read_a  input  1  fetch read request, level, held until resp_a.
REQ-006 SHALL have port address_a  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have port rdata_a  output  32  instruction word for address_a.
REQ-008 SHALL have port resp_a  output  1  one-cycle response strobe; rdata_a valid while high.
REQ-009 SHALL have port pmem_read  output  1  line-fill request to lower memory, level.
REQ-010 SHALL have port pmem_address  output  32  line-aligned fill address (bits [3:0] = 0).
REQ-011 SHALL have port pmem_rdata  input  128  fill line; word 0 in bits [31:0].
REQ-012 SHALL have port pmem_resp  input  1  fill complete; pmem_rdata valid this cycle.
REQ-013 SHALL have port perf_reset  input  1  synchronous clear of performance counters.
REQ-014 SHALL have ports hit_count, miss_count  output  32 each  performance counters.

Function
REQ-015 Address split SHALL be: offset [3:0], word select [3:2], index [3+log2(NUM_SETS):4], tag = remaining upper bits.
REQ-016 Storage per set SHALL be: valid bit, tag, 128-bit data line.
REQ-017 FSM SHALL have two states: IDLE and FILL.
REQ-018 IDLE, read_a=1, valid and tag match (hit): resp_a=1 and rdata_a = selected word combinationally in the same cycle; state stays IDLE.
REQ-019 IDLE, read_a=1, miss: resp_a=0; line address latched at the clock edge; transition to FILL.
REQ-020 FILL: pmem_read=1 and pmem_address = latched line address every cycle until pmem_resp.
REQ-021 FILL with pmem_resp=1: write pmem_rdata, tag and valid=1 into the latched index at the clock edge; transition to IDLE; resp_a=0 that cycle.
REQ-022 Hit-after-fill: the first IDLE cycle after a fill re-compares the current address_a; miss latency = fill cycles + 1.
REQ-023 address_a changing during FILL SHALL NOT alter the in-flight fill; the new address is compared on return to IDLE.
REQ-024 read_a dropping during FILL SHALL NOT abort the fill; line is still installed and no resp_a is generated.
REQ-025 A fill into a valid set SHALL overwrite it (no write-back; instruction-only, read-only).
REQ-026 read_a=0 in IDLE: resp_a=0, pmem_read=0, no state change.
REQ-027 rdata_a SHALL be don't-care when resp_a=0; resp_a SHALL never assert in FILL.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, clear all valid bits, resp_a=0, pmem_read=0, pmem_address=0, hit_count=0, miss_count=0.
REQ-029 Reset asserted mid-fill SHALL abandon the fill; a pmem_resp arriving after reset release in IDLE SHALL be ignored.
REQ-030 Tag and data arrays need not be reset.

Configuration
REQ-031 Macro INST_CACHE_PERF_EN defined: hit_count increments each IDLE cycle with read_a=1 and hit; miss_count increments each IDLE-to-FILL transition; both saturate at 32'hFFFFFFFF; perf_reset=1 clears both at the clock edge (clear has priority over increment).
REQ-032 Macro INST_CACHE_PERF_EN undefined: counter registers SHALL be omitted, hit_count and miss_count tied to 0, and perf_reset ignored.

Verification
REQ-033 Cold miss: after reset, read_a=1, address_a=0x00000064, pmem_resp on 3rd FILL cycle with line {W3,W2,W1,0xDEADBEEF} at 0x60 -> pmem_address=0x00000060, resp_a asserted next IDLE cycle with rdata_a=W1, miss_count=1, hit_count=1.
REQ-034 Hit streak: line 0x60 resident, addresses 0x60,0x64,0x68,0x6C on consecutive cycles -> resp_a=1 every cycle, no pmem_read, hit_count +4.
REQ-035 Conflict: NUM_SETS=8, fill 0x00000000 then access 0x00000080 -> miss, refill overwrites set 0; a later access to 0x00000000 misses again.
REQ-036 Reset mid-fill: reset_n low in 2nd FILL cycle -> pmem_read=0 immediately; after release, access to the same address misses (valid cleared); a stray pmem_resp is ignored.
REQ-037 Address change during fill: miss on 0x100, address_a switched to 0x204 before pmem_resp -> line 0x100 installed, then second miss filling 0x200.
REQ-038 Counter saturation and clear (INST_CACHE_PERF_EN): force hit_count near 0xFFFFFFFF, issue 3 hits -> stays 0xFFFFFFFF; perf_reset coincident with a hit -> 0.

Source files
------------

// File: rtl/inst_cache_if.sv
// Instruction-cache bus bundle.
// Carries the fetch-side request/response pair and the line-fill pair to
// lower memory.
//   slave  : the cache's view (fetch request in, fill request out)
//   master : the requester/memory's view (the bench drives this side)
// Handshakes: read_a is a level held by the requester until resp_a pulses
// for one cycle (rdata_a valid only while resp_a is high); pmem_read is a
// level held by the cache until pmem_resp pulses for one cycle with the
// fill line on pmem_rdata. No back-pressure exists on either response.
interface inst_cache_if;
  logic         read_a;
  logic [31:0]  address_a;
  logic [31:0]  rdata_a;
  logic         resp_a;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  read_a, address_a, pmem_rdata, pmem_resp,
    output rdata_a, resp_a, pmem_read, pmem_address
  );

  modport master (
    output read_a, address_a, pmem_rdata, pmem_resp,
    input  rdata_a, resp_a, pmem_read, pmem_address
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with 16-byte lines.
// A hit answers combinationally in the same cycle; a miss fetches the whole
// line from lower memory, installs it, and the request is re-compared in the
// first IDLE cycle after the fill.
// Optional feature macro: INST_CACHE_PERF_EN enables saturating hit/miss
// counters; without it the counters read as zero and perf_reset is ignored.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   bus (slave)       : fetch request/response and line-fill signals
//   perf_reset        : synchronous clear of the performance counters
//   hit_count         : hit counter (IDLE cycles with read_a and a hit)
//   miss_count        : miss counter (IDLE-to-FILL transitions)
//   dbg_state_o       : current FSM state, 0 = IDLE, 1 = FILL
module inst_cache #(
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  inst_cache_if.slave  bus,
  input  logic         perf_reset,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic         dbg_state_o
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 28 - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [27:0]        line_q, line_d;     // latched line address [31:4]
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [NUM_SETS];
  logic [LINE_W-1:0]  data_q [NUM_SETS];

  logic [IDX_W-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]   tag, fill_tag;
  logic [1:0]         wsel;
  logic               hit, fill_done;
  logic               resp, pmem_rd, hit_inc, miss_inc;

  assign idx      = bus.address_a[4 +: IDX_W];
  assign tag      = bus.address_a[31 -: TAG_W];
  assign wsel     = bus.address_a[3:2];
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[27 -: TAG_W];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_done = (state_q == FILL) && bus.pmem_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    resp     = 1'b0;
    pmem_rd  = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.read_a) begin
          if (hit) begin
            resp    = 1'b1;
            hit_inc = 1'b1;
          end else begin
            line_d   = bus.address_a[31:4];
            state_d  = FILL;
            miss_inc = 1'b1;
          end
        end
      end
      FILL: begin
        // The fill runs to completion regardless of read_a or address_a;
        // the current request is only looked at again back in IDLE.
        pmem_rd = 1'b1;
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.pmem_rdata;
    end
  end

  assign bus.resp_a       = resp;
  assign bus.rdata_a      = data_q[idx][{wsel, 5'b00000} +: 32];
  assign bus.pmem_read    = pmem_rd;
  assign bus.pmem_address = {line_q, 4'b0000};
  assign dbg_state_o      = state_q;

`ifdef INST_CACHE_PERF_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (perf_reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_inc && (hit_q != 32'hFFFF_FFFF))   hit_q  <= hit_q + 32'd1;
      if (miss_inc && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  logic unused_ok;
  assign unused_ok = ^{bus.address_a[1:0]};
`else
  assign hit_count  = '0;
  assign miss_count = '0;

  logic unused_ok;
  assign unused_ok = ^{bus.address_a[1:0], perf_reset, hit_inc, miss_inc};
`endif
endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache. The reference model is a per-set record
// of which line address is resident, plus a backing memory of random lines;
// hit/miss and returned words follow from address arithmetic alone.
module tb_inst_cache;
  localparam int NUM_SETS = 8;
`ifdef INST_CACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic perf_reset = 1'b0;
  logic [31:0] hit_count, miss_count;
  logic dbg_state_o;
  always #5 clk = ~clk;

  inst_cache_if bus();

  inst_cache #(.NUM_SETS(NUM_SETS), .LINE_BYTES(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .perf_reset(perf_reset),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state_o(dbg_state_o)
  );

  // ---------------- reference model ----------------
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [127:0] mem [int unsigned];
  bit           res_v    [NUM_SETS];
  logic [27:0]  res_line [NUM_SETS];
  logic [31:0]  exp_hits = 0;
  logic [31:0]  exp_misses = 0;

  function automatic logic [127:0] get_line(input logic [27:0] la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
    return mem[la];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SETS; i++) res_v[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Checks the IDLE cycle for the request currently on the bus (sampled at
  // the falling edge); reports whether the model predicts a hit.
  task automatic expect_idle(output bit was_hit);
    logic [31:0] a;
    int unsigned idx;
    @(negedge clk);
    a = bus.address_a;
    idx = (a / 16) % NUM_SETS;
    was_hit = res_v[idx] && (res_line[idx] == a[31:4]);
    chk("hit_count", hit_count, PERF ? exp_hits : 32'd0);
    chk("miss_count", miss_count, PERF ? exp_misses : 32'd0);
    chk("idle_state", {31'd0, dbg_state_o}, 32'd0);
    chk("idle_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
    chk("resp_a", {31'd0, bus.resp_a}, {31'd0, was_hit});
    if (was_hit) begin
      chk("rdata_a", bus.rdata_a, get_line(a[31:4])[a[3:2]*32 +: 32]);
      exp_hits = sat_inc(exp_hits);
    end else begin
      exp_misses = sat_inc(exp_misses);
    end
  endtask

  // Serves a fill for line la, answering on FILL cycle 'delay'.
  task automatic run_fill(input logic [27:0] la, input int delay);
    for (int i = 1; i <= delay; i++) begin
      @(posedge clk); #1;
      bus.pmem_resp  = (i == delay);
      bus.pmem_rdata = get_line(la);
      @(negedge clk);
      chk("fill_pmem_read", {31'd0, bus.pmem_read}, 32'd1);
      chk("fill_pmem_address", bus.pmem_address, {la, 4'h0});
      chk("fill_resp_a", {31'd0, bus.resp_a}, 32'd0);
    end
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    res_v[la % NUM_SETS]    = 1'b1;
    res_line[la % NUM_SETS] = la;
  endtask

  // One fetch, held until answered; read_a stays high afterwards so that
  // back-to-back calls form consecutive-cycle requests.
  task automatic do_access(input logic [31:0] a, input int delay, output bit first_hit);
    bit h;
    @(posedge clk); #1;
    bus.read_a = 1'b1;
    bus.address_a = a;
    expect_idle(first_hit);
    if (!first_hit) begin
      run_fill(a[31:4], delay);
      expect_idle(h);
      chk("hit_after_fill", {31'd0, h}, 32'd1);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.read_a = 1'b0;
    bus.address_a = $urandom;
    @(negedge clk);
    chk("noreq_resp_a", {31'd0, bus.resp_a}, 32'd0);
    chk("noreq_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit h;
    bus.read_a = 1'b0;
    bus.address_a = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp = 1'b0;
    model_reset();
    mem[28'h6] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {31'd0, dbg_state_o}, 32'd0);
    chk("reset_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
    chk("reset_pmem_address", bus.pmem_address, 32'd0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);

    // Cold miss on 0x64, fill answered on the 3rd FILL cycle.
    do_access(32'h64, 3, h);
    chk("cold_miss", {31'd0, h}, 32'd0);

    // Hit streak across the resident line.
    for (int i = 0; i < 4; i++) begin
      do_access(32'h60 + 32'(i * 4), 1, h);
      chk("streak_hit", {31'd0, h}, 32'd1);
    end

    // Conflict in set 0.
    do_access(32'h0, 2, h);
    do_access(32'h80, 1, h);
    chk("conflict_miss", {31'd0, h}, 32'd0);
    do_access(32'h0, 1, h);
    chk("conflict_remiss", {31'd0, h}, 32'd0);
    idle_cycle();

    // Reset during the second FILL cycle, then a stray pmem_resp.
    @(posedge clk); #1;
    bus.read_a = 1'b1;
    bus.address_a = 32'h300;
    expect_idle(h);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
    chk("rst_mid_state", {31'd0, dbg_state_o}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.read_a = 1'b0;
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = get_line(28'h30);
    @(negedge clk);
    chk("stray_resp_a", {31'd0, bus.resp_a}, 32'd0);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    chk("stray_state", {31'd0, dbg_state_o}, 32'd0);
    chk("stray_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
    do_access(32'h300, 2, h);
    chk("post_reset_miss", {31'd0, h}, 32'd0);

    // Address switched during a fill; read_a dropped mid-fill too.
    @(posedge clk); #1;
    bus.read_a = 1'b1;
    bus.address_a = 32'h100;
    expect_idle(h);
    chk("chg_first_miss", {31'd0, h}, 32'd0);
    @(posedge clk); #1;
    bus.address_a = 32'h204;
    bus.read_a = 1'b0;
    @(negedge clk);
    chk("chg_pmem_address", bus.pmem_address, 32'h100);
    chk("chg_noresp", {31'd0, bus.resp_a}, 32'd0);
    bus.read_a = 1'b1;
    run_fill(28'h10, 2);
    expect_idle(h);
    chk("chg_second_miss", {31'd0, h}, 32'd0);
    run_fill(28'h20, 1);
    expect_idle(h);
    chk("chg_second_hit", {31'd0, h}, 32'd1);
    idle_cycle();

    // Random traffic over a small window so sets conflict often.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      else do_access($urandom_range(0, 32'h3FF), $urandom_range(1, 4), h);
    end
    idle_cycle();

`ifdef INST_CACHE_PERF_EN
    // Saturation and clear.
    do_access(32'h3F0, 1, h);
    @(posedge clk); #1;
    bus.read_a = 1'b0;
    force dut.hit_q = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.hit_q;
    exp_hits = 32'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) do_access(32'h3F4, 1, h);
    @(posedge clk); #1;
    perf_reset = 1'b1;
    @(negedge clk);
    chk("sat_hit_count", hit_count, 32'hFFFF_FFFF);
    chk("perf_clr_resp", {31'd0, bus.resp_a}, 32'd1);
    @(posedge clk); #1;
    perf_reset = 1'b0;
    bus.read_a = 1'b0;
    @(negedge clk);
    chk("clr_hit_count", hit_count, 32'd0);
    chk("clr_miss_count", miss_count, 32'd0);
`else
    // perf_reset must be harmless when counters are absent.
    @(posedge clk); #1;
    perf_reset = 1'b1;
    @(negedge clk);
    chk("noperf_hit_count", hit_count, 32'd0);
    @(posedge clk); #1;
    perf_reset = 1'b0;
`endif

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
